// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite single-port SRAM slave.
// Word-organised memory with byte-lane writes, optional wait states and a
// two-cycle ERROR response for bad size, misalignment or out-of-range addresses.
module ahb3lite_sram_slave #(
  parameter int MEM_WORDS   = 256,  // depth in 32-bit words, power of two
  parameter int WAIT_STATES = 0     // wait cycles per OKAY data phase, 0..3
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         AW      = $clog2(MEM_WORDS);
  localparam logic [1:0] WS_LAST = 2'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    wait_q,  wait_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [1:0]    lane_q,  lane_d;
  logic [1:0]    size_q,  size_d;
  logic          write_q, write_d;

  logic [31:0]   mem_q [MEM_WORDS];

  // Burst type and protection are accepted but carry no meaning for an SRAM.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT};

  logic       accept;
  logic       size_bad;
  logic       misaligned;
  logic       out_of_range;
  logic       addr_err;
  logic       data_done;
  logic       ready_for_addr;
  logic       mem_we;
  logic [3:0] byte_en;

  assign accept       = HSEL & HREADY & HTRANS[1];
  assign size_bad     = (HSIZE > 3'd2);
  // Upper address bits are only range-checked; the array index never wraps.
  assign out_of_range = |HADDR[31:AW+2];
  assign addr_err     = size_bad | misaligned | out_of_range;

  // The last cycle of an OKAY data phase is the one with the wait count exhausted.
  assign data_done      = (state_q == ST_DATA) && (wait_q == WS_LAST);
  assign ready_for_addr = (state_q == ST_IDLE) || (state_q == ST_ERR2) || data_done;

  // Alignment check for the size requested in the address phase.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    misaligned = 1'b0;
    case (HSIZE)
      3'd1:    misaligned = HADDR[0];
      3'd2:    misaligned = |HADDR[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Next-state logic: wait counting, error sequencing and address-phase capture.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
    if ((state_q == ST_DATA) && !data_done) begin
      wait_d = wait_q + 2'd1;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (ready_for_addr) begin
      wait_d = 2'd0;
      if (accept) begin
        state_d = addr_err ? ST_ERR1 : ST_DATA;
        addr_d  = HADDR[AW+1:2];
        lane_d  = HADDR[1:0];
        size_d  = HSIZE[1:0];
        write_d = HWRITE;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Control registers with synchronous active-high reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= ST_IDLE;
      wait_q  <= 2'd0;
      addr_q  <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  // Response outputs decoded from the current state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_DATA: HREADYOUT = data_done;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // Little-endian byte lanes selected by the registered size and low address bits.
  always_comb begin
    byte_en = 4'b1111;
    case (size_q)
      2'd0:    byte_en = 4'b0001 << lane_q;
      2'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // A write commits only on the edge that completes its data phase, never under reset.
  assign mem_we = data_done & write_q & ~HRESET;

  // Memory array write port.
  always_ff @(posedge HCLK) begin
    // NOTE: the array has no reset on purpose; contents survive HRESET and it maps onto plain RAM.
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Read data is driven only during a read data phase, otherwise held at zero.
  assign HRDATA = ((state_q == ST_DATA) && !write_q) ? mem_q[addr_q] : 32'h0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Self-checking bench for ahb3lite_sram_slave.
// Two instances: index 0 with no wait states, index 1 with two wait states.
// Each instance's HREADY is looped back from its own HREADYOUT (single-slave bus).
`timescale 1ns/1ps
module tb_ahb3lite_sram_slave;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  hreset;
  logic [1:0]            hsel;
  logic [1:0][31:0]      haddr;
  logic [1:0]            hwrite;
  logic [1:0][1:0]       htrans;
  logic [1:0][2:0]       hsize;
  logic [1:0][31:0]      hwdata;
  logic [1:0]            hreadyout;
  logic [1:0]            hresp;
  logic [1:0][31:0]      hrdata;

  ahb3lite_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HWRITE(hwrite[0]), .HTRANS(htrans[0]), .HSIZE(hsize[0]),
    .HBURST(3'b000), .HPROT(4'b0011), .HWDATA(hwdata[0]),
    .HREADY(hreadyout[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
    .HRDATA(hrdata[0])
  );

  ahb3lite_sram_slave #(.MEM_WORDS(256), .WAIT_STATES(2)) dut1 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HWRITE(hwrite[1]), .HTRANS(htrans[1]), .HSIZE(hsize[1]),
    .HBURST(3'b001), .HPROT(4'b0011), .HWDATA(hwdata[1]),
    .HREADY(hreadyout[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
    .HRDATA(hrdata[1])
  );

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          waits;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // One bus cycle (plus any stall): present an address phase, complete the
  // outstanding data phase, score it, and queue the new transfer if accepted.
  task automatic step(input int d, input logic sel, input logic [1:0] trans,
                      input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic err, input string name);
    exp_t e;
    exp_t cur;
    int   waits = 0;
    bit   done  = 1'b0;
    hsel[d]   = sel;
    htrans[d] = trans;
    hwrite[d] = wr;
    haddr[d]  = addr;
    hsize[d]  = size;
    hwdata[d] = (sb.size() != 0) ? sb[0].wdata : wdata;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        vectors++;
        if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) begin
          miscompares++;
          $display("FAIL %s idle_resp: ready=%b resp=%b rdata=%h, expected 1 0 00000000",
                   name, hreadyout[d], hresp[d], hrdata[d]);
        end
      end else begin
        cur = sb[0];
        vectors++;
        if (hresp[d] !== cur.err) begin
          miscompares++;
          $display("FAIL %s hresp: got %b expected %b (cycle %0d)", cur.name, hresp[d], cur.err, waits);
        end
        if (cur.wr || cur.err) begin
          vectors++;
          if (hrdata[d] !== 32'h0) begin
            miscompares++;
            $display("FAIL %s hrdata_zero: got %h expected 00000000", cur.name, hrdata[d]);
          end
        end
        if (hreadyout[d] === 1'b1) begin
          void'(sb.pop_front());
          vectors++;
          if (waits != cur.waits) begin
            miscompares++;
            $display("FAIL %s wait_count: got %0d expected %0d", cur.name, waits, cur.waits);
          end
          if (!cur.wr && !cur.err) begin
            vectors++;
            if (hrdata[d] !== cur.rdata) begin
              miscompares++;
              $display("FAIL %s rdata: got %h expected %h", cur.name, hrdata[d], cur.rdata);
            end
          end
        end
      end
      if (hreadyout[d] === 1'b1) begin
        if (sel && trans[1]) begin
          e.wr    = wr;
          e.wdata = wdata;
          e.rdata = rdata;
          e.err   = err;
          e.waits = err ? 1 : ws_of(d);
          e.name  = name;
          sb.push_back(e);
        end
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: HREADYOUT stuck at %b, expected 1 within 16 cycles", name, hreadyout[d]);
    end
  endtask

  task automatic idle(input int d, input string name);
    step(d, 1'b0, T_IDLE, 1'b0, 32'h0, 3'd2, 32'h0, 32'h0, 1'b0, name);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; htrans[d] = T_IDLE; hwrite[d] = 1'b0;
      haddr[d] = 32'h0; hsize[d] = 3'd2; hwdata[d] = 32'h0;
    end
    hreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0 || hrdata[d] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: ready=%b resp=%b rdata=%h, expected 1 0 00000000",
                 d, hreadyout[d], hresp[d], hrdata[d]);
      end
    end
    hreset = 1'b0;
  endtask

  // Back-to-back word write then read; the first address phase follows reset directly.
  task automatic test_word_rw();
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, "w_word_10");
    step(0, 1'b1, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0, "r_word_10");
    idle(0, "word_drain");
  endtask

  task automatic test_byte_lanes();
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h20, 3'd2, 32'h11223344, 32'h0,        1'b0, "w_word_20");
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h22, 3'd0, 32'h00AA0000, 32'h0,        1'b0, "w_byte_22");
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h24, 3'd2, 32'h01020304, 32'h0,        1'b0, "w_word_24");
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h26, 3'd1, 32'hBEEF0000, 32'h0,        1'b0, "w_half_26");
    step(0, 1'b1, T_NONSEQ, 1'b0, 32'h20, 3'd2, 32'h0,        32'h11AA3344, 1'b0, "r_lanes_20");
    step(0, 1'b1, T_NONSEQ, 1'b0, 32'h24, 3'd2, 32'h0,        32'hBEEF0304, 1'b0, "r_lanes_24");
    idle(0, "lanes_drain");
  endtask

  task automatic test_deselect();
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h30, 3'd2, 32'hCAFEF00D, 32'h0, 1'b0, "w_word_30");
    idle(0, "desel_drain");
    step(0, 1'b0, T_NONSEQ, 1'b1, 32'h30, 3'd2, 32'h00000055, 32'h0, 1'b0, "w_unselected_30");
    step(0, 1'b1, T_BUSY,   1'b1, 32'h30, 3'd2, 32'h00000055, 32'h0, 1'b0, "w_busy_30");
    step(0, 1'b1, T_NONSEQ, 1'b0, 32'h30, 3'd2, 32'h00000055, 32'hCAFEF00D, 1'b0, "r_desel_30");
    idle(0, "desel_drain2");
  endtask

  // Range, alignment and size errors, each followed immediately from ERR2.
  task automatic test_errors();
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h00,  3'd2, 32'hA5A5A5A5, 32'h0,        1'b0, "w_word_00");
    step(0, 1'b1, T_NONSEQ, 1'b0, 32'h400, 3'd2, 32'h0,        32'h0,        1'b1, "r_range_400");
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, 32'h0,        1'b1, "w_range_400");
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h01,  3'd1, 32'hFFFFFFFF, 32'h0,        1'b1, "w_misalign_01");
    step(0, 1'b1, T_NONSEQ, 1'b1, 32'h00,  3'd3, 32'hFFFFFFFF, 32'h0,        1'b1, "w_size3_00");
    step(0, 1'b1, T_NONSEQ, 1'b0, 32'h00,  3'd2, 32'h0,        32'hA5A5A5A5, 1'b0, "r_after_err_00");
    idle(0, "err_drain");
  endtask

  task automatic test_wait_states();
    step(1, 1'b1, T_NONSEQ, 1'b1, 32'h10, 3'd2, 32'h0BADF00D, 32'h0,        1'b0, "ws_w_10");
    idle(1, "ws_drain");
    step(1, 1'b1, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0,        32'h0BADF00D, 1'b0, "ws_r_10");
    step(1, 1'b1, T_NONSEQ, 1'b1, 32'h14, 3'd2, 32'h00000007, 32'h0,        1'b0, "ws_w_14");
    step(1, 1'b1, T_NONSEQ, 1'b0, 32'h14, 3'd2, 32'h0,        32'h00000007, 1'b0, "ws_r_14");
    idle(1, "ws_drain2");
  endtask

  // Reset lands in the first wait cycle of a write; the word must keep its old value.
  task automatic test_reset_abort();
    step(1, 1'b1, T_NONSEQ, 1'b1, 32'h40, 3'd2, 32'h12345678, 32'h0, 1'b0, "abort_w_prior");
    idle(1, "abort_drain");
    step(1, 1'b1, T_NONSEQ, 1'b1, 32'h40, 3'd2, 32'hFFFFFFFF, 32'h0, 1'b0, "abort_w_new");
    hsel[1]   = 1'b0;
    htrans[1] = T_IDLE;
    hwdata[1] = 32'hFFFFFFFF;
    @(negedge clk);
    vectors++;
    if (hreadyout[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_in_wait: HREADYOUT got %b expected 0", hreadyout[1]);
    end
    hreset = 1'b1;
    @(posedge clk);
    #1;
    hreset = 1'b0;
    sb.delete();
    step(1, 1'b1, T_NONSEQ, 1'b0, 32'h40, 3'd2, 32'h0, 32'h12345678, 1'b0, "abort_r_40");
    idle(1, "abort_drain2");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_deselect();
    test_errors();
    test_wait_states();
    test_reset_abort();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
